// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO in front of a UART transmitter.
// Bytes from the host write port are buffered and launched one at a time
// as a one-cycle start pulse with the byte held on uart_txin. After the
// transmitter reports txdone, a fixed guard gap elapses before the next launch.
module uart_tx_fifo #(
   parameter int DEPTH      = 16,
   parameter int AW         = 4,
   parameter int GAP_CYCLES = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [7:0]    wr_data,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count,
   output logic          overflow,
   output logic          busy,
   output logic          uart_start,
   output logic [7:0]    uart_txin,
   input  logic          uart_txdone
);

   localparam int            GW         = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);
   localparam logic [AW:0]   COUNT_FULL = (AW + 1)'(DEPTH);
   localparam logic [AW:0]   COUNT_ZERO = (AW + 1)'(0);
   localparam logic [AW:0]   COUNT_ONE  = (AW + 1)'(1);
   localparam logic [AW-1:0] PTR_ONE    = AW'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_GAP  = 2'd2
   } state_t;

   logic [7:0]    mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic          full_r;
   logic          empty_r;
   logic          overflow_r;

   state_t        state_r;
   logic [GW-1:0] gap_cnt_r;
   logic          start_r;
   logic [7:0]    txin_r;
   logic          busy_r;

   logic          push_s;
   logic          pop_s;
   logic [AW:0]   count_next_s;

   // Accept/launch decisions use only registered flags, so a write while full
   // is dropped even when a launch frees a slot on the same edge.
   always_comb begin
      push_s       = wr_en && !full_r;
      pop_s        = (state_r == S_IDLE) && !empty_r;
      count_next_s = count_r;
      if (push_s && !pop_s) begin
         count_next_s = count_r + COUNT_ONE;
      end else if (pop_s && !push_s) begin
         count_next_s = count_r - COUNT_ONE;
      end else begin
         count_next_s = count_r;
      end
   end

   // Storage array: written on accepted pushes, not cleared by reset.
   always_ff @(posedge clk) begin
      if (push_s && !rst) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // FIFO bookkeeping: wrapping pointers, occupancy, registered flags, sticky overflow.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= COUNT_ZERO;
         full_r     <= 1'b0;
         empty_r    <= 1'b1;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         count_r    <= count_next_s;
         full_r     <= (count_next_s == COUNT_FULL);
         empty_r    <= (count_next_s == COUNT_ZERO);
         overflow_r <= overflow_r | (wr_en && full_r);
      end
   end

   // Pacing FSM: launch from IDLE, wait for txdone, then count out the guard gap.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r   <= S_IDLE;
         gap_cnt_r <= '0;
         start_r   <= 1'b0;
         txin_r    <= 8'h00;
         busy_r    <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (pop_s) begin
                  txin_r  <= mem_r[rd_ptr_r];
                  start_r <= 1'b1;
                  busy_r  <= 1'b1;
                  state_r <= S_WAIT;
               end else begin
                  start_r <= 1'b0;
                  busy_r  <= 1'b0;
               end
            end
            S_WAIT: begin
               start_r <= 1'b0;
               busy_r  <= 1'b1;
               if (uart_txdone) begin
                  gap_cnt_r <= '0;
                  state_r   <= S_GAP;
               end
            end
            S_GAP: begin
               start_r <= 1'b0;
               if (gap_cnt_r == GAP_LAST) begin
                  gap_cnt_r <= '0;
                  busy_r    <= 1'b0;
                  state_r   <= S_IDLE;
               end else begin
                  gap_cnt_r <= gap_cnt_r + GW'(1);
                  busy_r    <= 1'b1;
               end
            end
            default: begin
               gap_cnt_r <= '0;
               start_r   <= 1'b0;
               busy_r    <= 1'b0;
               state_r   <= S_IDLE;
            end
         endcase
      end
   end

   assign full       = full_r;
   assign empty      = empty_r;
   assign count      = count_r;
   assign overflow   = overflow_r;
   assign busy       = busy_r;
   assign uart_start = start_r;
   assign uart_txin  = txin_r;

endmodule
